encoding_cont_v2: RTL and testbench

Systematic Reed-Solomon RS(15,9) encoder over GF(16) with primitive polynomial x^4+x+1 (alpha = 4'b0010), correcting up to t=3 symbol errors. It accepts a packed 9-symbol message on a toggle-style request. It computes the 6 parity symbols with a sequential LFSR divider and presents a registered, packed 15-symbol codeword. The codeword feeds the channel/error-injection path and then the companion RS(15,9) decoder (decodingCont).

---
 rtl/encoding_cont_v2.sv | 201 ++++++++++++++++++++
 tb/tb_encoding_cont_v2.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoding_cont_v2.sv
// -----------------------------------------------------------------------------
// encoding_cont_v2
//
// Systematic Reed-Solomon RS(15,9) encoder over GF(16), primitive polynomial
// x^4 + x + 1 (alpha = 4'b0010).
//
// The six parity symbols are produced by a sequential LFSR divider that
// consumes one message symbol per clock, highest degree first. The finished
// codeword is presented on a registered output and feeds the channel /
// error-injection path ahead of the companion RS(15,9) decoder.
//
// Generator polynomial g(x), coefficients x^6..x^0:
//   1, a^10, a^14, a^4, a^6, a^9, a^6  =  hex 1,7,9,3,C,A,C
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   message        in  36   symbol j at [4j+3:4j]; coefficient of x^(j+6)
//   encodeMessage  in   1   request toggle; every level change is a request
//   encodedMessage out 60   codeword; symbol i at [4i+3:4i]
//                           [59:24] = message, [23:0] = parity p5..p0
//   encoderBusy    out  1   high while an encode is in progress
//
// Handshake
//   A request is pending whenever encodeMessage differs from its copy
//   registered on the previous clock. It is accepted only in IDLE. A toggle
//   that arrives while busy is absorbed by that register and therefore
//   dropped rather than queued. encoderBusy stays high for exactly 10
//   cycles (9 SHIFT + 1 DONE), and encodedMessage changes only on the edge
//   that leaves DONE, so it never shows a partial remainder.
// -----------------------------------------------------------------------------
module encoding_cont_v2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [35:0] message,
    input  logic        encodeMessage,
    output logic [59:0] encodedMessage,
    output logic        encoderBusy
);

    // Generator coefficients g5..g0 (g6 = 1 is implicit in the feedback).
    localparam logic [3:0] G5 = 4'h7;
    localparam logic [3:0] G4 = 4'h9;
    localparam logic [3:0] G3 = 4'h3;
    localparam logic [3:0] G2 = 4'hC;
    localparam logic [3:0] G1 = 4'hA;
    localparam logic [3:0] G0 = 4'hC;

    localparam logic [3:0] LAST_SHIFT = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // GF(16) multiply. With a constant second operand this collapses to a
    // small XOR network. Each step multiplies the running term by alpha:
    // shift left and fold x^4 back in as x + 1.
    function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] term;
        acc  = 4'h0;
        term = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ term;
            end
            term = {term[2:0], 1'b0} ^ (term[3] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state;
    state_t            stateNext;
    logic              reqQ;
    logic [35:0]       msgQ;
    logic [3:0]        counter;
    logic [5:0][3:0]   parity;

    // ------------------------------------------------------------------
    // Combinational control / datapath
    // ------------------------------------------------------------------
    logic              reqPending;
    logic              acceptReq;
    logic              doShift;
    logic              loadOut;
    logic [3:0]        symIdx;
    logic [5:0]        symBase;
    logic [3:0]        inSym;
    logic [3:0]        fb;
    logic [5:0][3:0]   parityShifted;

    assign reqPending = (encodeMessage != reqQ);

    // Symbols are fed highest degree first: counter 0 selects symbol 8.
    assign symIdx  = LAST_SHIFT - counter;
    assign symBase = {symIdx, 2'b00};
    assign inSym   = msgQ[symBase +: 4];

    // One division step of the LFSR remainder.
    assign fb               = inSym ^ parity[5];
    assign parityShifted[5] = parity[4] ^ gfMul(fb, G5);
    assign parityShifted[4] = parity[3] ^ gfMul(fb, G4);
    assign parityShifted[3] = parity[2] ^ gfMul(fb, G3);
    assign parityShifted[2] = parity[1] ^ gfMul(fb, G2);
    assign parityShifted[1] = parity[0] ^ gfMul(fb, G1);
    assign parityShifted[0] = gfMul(fb, G0);

    always_comb begin
        stateNext   = state;
        acceptReq   = 1'b0;
        doShift     = 1'b0;
        loadOut     = 1'b0;
        encoderBusy = 1'b0;

        unique case (state)
            IDLE: begin
                if (reqPending) begin
                    acceptReq = 1'b1;
                    stateNext = SHIFT;
                end
            end

            SHIFT: begin
                encoderBusy = 1'b1;
                doShift     = 1'b1;
                if (counter == LAST_SHIFT) begin
                    stateNext = DONE;
                end
            end

            DONE: begin
                encoderBusy = 1'b1;
                loadOut     = 1'b1;
                stateNext   = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Request edge detector. It samples every clock regardless of state,
    // which is what makes a toggle seen while busy disappear. Clearing it
    // to 0 means a high encodeMessage at reset release is one request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqQ <= 1'b0;
        end else begin
            reqQ <= encodeMessage;
        end
    end

    // ------------------------------------------------------------------
    // Message capture, shift counter and parity remainder
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msgQ    <= '0;
            counter <= '0;
            parity  <= '0;
        end else if (acceptReq) begin
            msgQ    <= message;
            counter <= '0;
            parity  <= '0;
        end else if (doShift) begin
            parity  <= parityShifted;
            counter <= (counter == LAST_SHIFT) ? 4'd0 : counter + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Codeword output: updated only once the remainder is complete.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encodedMessage <= '0;
        end else if (loadOut) begin
            encodedMessage <= {msgQ, parity};
        end
    end

endmodule

// File: tb/tb_encoding_cont_v2.sv
// -----------------------------------------------------------------------------
// tb_encoding_cont_v2
//
// Directed bench for the RS(15,9) encoder. Expected codewords are
// hand-derived constants. Syndromes are evaluated with log/antilog tables
// that the bench builds itself. Linearity is checked on random pairs.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_encoding_cont_v2;

    logic        clk;
    logic        rst_n;
    logic [35:0] message;
    logic        encodeMessage;
    logic [59:0] encodedMessage;
    logic        encoderBusy;

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] gfExp [15];
    logic [3:0] gfLog [16];

    localparam logic [35:0] UNIT_MSG = 36'h000000001;
    localparam logic [59:0] UNIT_CW  = 60'h000000001793CAC;
    localparam logic [35:0] REF_MSG  = 36'hBF614A2AC;

    encoding_cont_v2 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .message        (message),
        .encodeMessage  (encodeMessage),
        .encodedMessage (encodedMessage),
        .encoderBusy    (encoderBusy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- GF(16) model via tables ----------------
    task automatic buildTables();
        logic [3:0] v;
        v = 4'h1;
        gfLog[0] = 4'h0;
        for (int i = 0; i < 15; i++) begin
            gfExp[i] = v;
            gfLog[v] = i[3:0];
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
        end
    endtask

    function automatic logic [3:0] tblMul(input logic [3:0] a, input logic [3:0] b);
        int e;
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        e = (int'(gfLog[a]) + int'(gfLog[b])) % 15;
        return gfExp[e];
    endfunction

    // c(alpha^j) by Horner, highest-degree symbol first.
    function automatic logic [3:0] syndrome(input logic [59:0] cw, input int j);
        logic [3:0] s;
        logic [3:0] aj;
        aj = gfExp[j % 15];
        s  = 4'h0;
        for (int i = 14; i >= 0; i--) begin
            s = tblMul(s, aj) ^ cw[4*i +: 4];
        end
        return s;
    endfunction

    task automatic checkSyndromes(input string tag, input logic [59:0] cw);
        for (int j = 1; j <= 6; j++) begin
            checkValue($sformatf("%s_syn%0d", tag, j), 64'(syndrome(cw, j)), 64'h0);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called on a falling edge. Counts the falling edges at which the DUT
    // reports busy (bounded) and returns the codeword seen once busy drops.
    task automatic waitDone(input string tag, output logic [59:0] cw);
        int len;
        len = 0;
        @(negedge clk);
        while (encoderBusy && len < 50) begin
            len++;
            @(negedge clk);
        end
        checkValue({tag, "_busy_len"}, 64'(len), 64'd10);
        cw = encodedMessage;
    endtask

    task automatic runEncode(input string tag, input logic [35:0] msg, output logic [59:0] cw);
        message       = msg;
        encodeMessage = ~encodeMessage;
        waitDone(tag, cw);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [59:0] cw;
        logic [59:0] refCw;
        logic [59:0] ea;
        logic [59:0] eb;
        logic [59:0] eab;
        logic [35:0] ma;
        logic [35:0] mb;
        logic        sawBusy;
        int          len;

        buildTables();
        rst_n         = 1'b0;
        message       = '0;
        encodeMessage = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        checkValue("rst_cw", 64'(encodedMessage), 64'h0);
        checkValue("rst_busy", 64'(encoderBusy), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("idle_busy", 64'(encoderBusy), 64'h0);

        // Zero message
        runEncode("zero", 36'h0, cw);
        checkValue("zero_cw", 64'(cw), 64'h0);

        // Unit message: codeword equals g(x)
        runEncode("unit", UNIT_MSG, cw);
        checkValue("unit_cw", 64'(cw), 64'(UNIT_CW));

        // Reference message
        runEncode("ref", REF_MSG, refCw);
        checkValue("ref_msg_field", 64'(refCw[59:24]), 64'(REF_MSG));
        checkSyndromes("ref", refCw);

        // Toggle while busy: dropped, and the message change is ignored
        message       = UNIT_MSG;
        encodeMessage = ~encodeMessage;
        len = 0;
        @(negedge clk);
        while (encoderBusy && len < 50) begin
            len++;
            if (len == 3) begin
                message       = REF_MSG;
                encodeMessage = ~encodeMessage;
            end
            @(negedge clk);
        end
        checkValue("busy_toggle_len", 64'(len), 64'd10);
        checkValue("busy_toggle_cw", 64'(encodedMessage), 64'(UNIT_CW));
        sawBusy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (encoderBusy) sawBusy = 1'b1;
        end
        checkValue("busy_toggle_dropped", 64'(sawBusy), 64'h0);
        checkValue("busy_toggle_hold", 64'(encodedMessage), 64'(UNIT_CW));

        // New request after busy falls is accepted
        runEncode("reenc", REF_MSG, cw);
        checkValue("reenc_cw", 64'(cw), 64'(refCw));

        // Two toggles on consecutive cycles in IDLE: one encode only
        message       = UNIT_MSG;
        encodeMessage = ~encodeMessage;
        @(negedge clk);
        encodeMessage = ~encodeMessage;
        len = 1;
        @(negedge clk);
        while (encoderBusy && len < 50) begin
            len++;
            @(negedge clk);
        end
        checkValue("dbl_len", 64'(len), 64'd10);
        checkValue("dbl_cw", 64'(encodedMessage), 64'(UNIT_CW));
        sawBusy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (encoderBusy) sawBusy = 1'b1;
        end
        checkValue("dbl_second_dropped", 64'(sawBusy), 64'h0);

        // Linearity on random pairs
        for (int p = 0; p < 20; p++) begin
            ma = {$urandom_range(15, 0), $urandom()};
            mb = {$urandom_range(15, 0), $urandom()};
            runEncode("lin_a", ma, ea);
            runEncode("lin_b", mb, eb);
            runEncode("lin_ab", ma ^ mb, eab);
            checkValue($sformatf("lin_%0d", p), 64'(eab), 64'(ea ^ eb));
            checkValue($sformatf("lin_msg_%0d", p), 64'(eab[59:24]), 64'(ma ^ mb));
        end
        checkSyndromes("lin_last", eab);

        // Reset mid-SHIFT: outputs clear at once, no codeword afterwards
        message       = REF_MSG;
        encodeMessage = ~encodeMessage;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkValue("midrst_cw", 64'(encodedMessage), 64'h0);
        checkValue("midrst_busy", 64'(encoderBusy), 64'h0);
        encodeMessage = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sawBusy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (encoderBusy) sawBusy = 1'b1;
        end
        checkValue("midrst_no_busy", 64'(sawBusy), 64'h0);
        checkValue("midrst_no_cw", 64'(encodedMessage), 64'h0);

        // encodeMessage high at reset release counts as one request
        @(negedge clk);
        rst_n         = 1'b0;
        message       = UNIT_MSG;
        encodeMessage = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        waitDone("relreq", cw);
        checkValue("relreq_cw", 64'(cw), 64'(UNIT_CW));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
